// File: rtl/cmd_regserver.sv
// ASCII command server: parses w/r/o commands byte-serially, owns a register file,
// dispatches ops to an external compute unit and streams k/e/hex replies back.
module cmd_regserver #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [OPW-1:0]   op_code,
  output logic [WIDTH-1:0] op_src0,
  output logic [WIDTH-1:0] op_src1,
  output logic [3:0]       op_dst,
  input  logic             res_valid,
  input  logic [3:0]       res_dst,
  input  logic [WIDTH-1:0] res_data,
  output logic [15:0]      err_count
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [4:0] HEX_LAST = 5'(N - 1);
  localparam logic [4:0] N5 = 5'(N);
  localparam logic [7:0] REG_LIM = 8'(48 + NREGS);

  typedef enum logic [3:0] {
    IDLE, REGSEL, HEXDATA, OPNAME, OPREGS, EOL, ISSUE, ERRSKIP, REPLY
  } state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= "9") ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  function automatic logic is_reg(input logic [7:0] b);
    return (b >= "0") && (b < REG_LIM);
  endfunction

  function automatic logic [7:0] to_asc(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h57 + {4'h0, n};
  endfunction

  function automatic logic [OPW-1:0] mnem(input logic [23:0] m);
    case (m)
      "add":   return OPW'(1);
      "sub":   return OPW'(2);
      "mul":   return OPW'(3);
      "fab":   return OPW'(4);
      "max":   return OPW'(5);
      "min":   return OPW'(6);
      "neg":   return OPW'(7);
      "div":   return OPW'(8);
      "sqr":   return OPW'(9);
      "sin":   return OPW'(10);
      "cos":   return OPW'(11);
      default: return '0;
    endcase
  endfunction

  function automatic logic [N*8-1:0] hex_str(input logic [WIDTH-1:0] v);
    logic [N*8-1:0] s;
    for (int i = 0; i < N; i++) s[i*8 +: 8] = to_asc(v[i*4 +: 4]);
    return s;
  endfunction

  state_t           state, state_nx;
  logic [7:0]       cmd;
  logic [IW-1:0]    sel, s0, s1;
  logic [3:0]       dst;
  logic [WIDTH-1:0] acc;
  logic [4:0]       cnt;
  logic [15:0]      name;
  logic [OPW-1:0]   code;
  logic [WIDTH-1:0] regs [NREGS];
  logic [N*8-1:0]   rbuf;
  logic [4:0]       rcnt;
  logic [N*8-1:0]   rd_str;
  logic rx_fire, tx_fire, bad, wr_host, issue, rep_k, rep_e, rep_hex;

  assign rx_ready = (state != ISSUE) && (state != REPLY);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign rd_str   = hex_str(regs[sel]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bad      = 1'b0;
    wr_host  = 1'b0;
    issue    = 1'b0;
    rep_k    = 1'b0;
    rep_e    = 1'b0;
    rep_hex  = 1'b0;
    if (rx_fire && rx_data != CR) begin
      case (state)
        IDLE: begin
          if (rx_data == "w" || rx_data == "r") state_nx = REGSEL;
          else if (rx_data == "o")             state_nx = OPNAME;
          else if (rx_data != LF)              bad = 1'b1;
        end
        REGSEL: begin
          if (!is_reg(rx_data))  bad = 1'b1;
          else if (cmd == "w")   state_nx = HEXDATA;
          else                   state_nx = EOL;
        end
        HEXDATA: begin
          if (!is_hex(rx_data))      bad = 1'b1;
          else if (cnt == HEX_LAST) state_nx = EOL;
        end
        OPNAME: begin
          if (rx_data == LF) bad = 1'b1;
          else if (cnt == 5'd2) begin
            if (mnem({name, rx_data}) == '0) bad = 1'b1;
            else                             state_nx = OPREGS;
          end
        end
        OPREGS: begin
          if (!is_reg(rx_data))  bad = 1'b1;
          else if (cnt == 5'd2)  state_nx = EOL;
        end
        EOL: begin
          if (rx_data != LF) bad = 1'b1;
          else if (cmd == "w") begin
            wr_host  = 1'b1;
            rep_k    = 1'b1;
            state_nx = REPLY;
          end else if (cmd == "r") begin
            rep_hex  = 1'b1;
            state_nx = REPLY;
          end else begin
            issue    = 1'b1;
            state_nx = ISSUE;
          end
        end
        ERRSKIP: begin
          if (rx_data == LF) begin
            rep_e    = 1'b1;
            state_nx = REPLY;
          end
        end
        default: ;
      endcase
      // An error on the terminating LF itself has nothing left to skip.
      if (bad) begin
        if (rx_data == LF) begin
          rep_e    = 1'b1;
          state_nx = REPLY;
        end else begin
          state_nx = ERRSKIP;
        end
      end
    end
    if (state == ISSUE && op_valid && op_ready) begin
      rep_k    = 1'b1;
      state_nx = REPLY;
    end
    if (state == REPLY && tx_fire && rcnt == 5'd0) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      sel       <= '0;
      s0        <= '0;
      s1        <= '0;
      dst       <= '0;
      acc       <= '0;
      cnt       <= '0;
      name      <= '0;
      code      <= '0;
      rbuf      <= '0;
      rcnt      <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      op_valid  <= 1'b0;
      op_code   <= '0;
      op_src0   <= '0;
      op_src1   <= '0;
      op_dst    <= '0;
      err_count <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (rx_fire && rx_data != CR) begin
        case (state)
          IDLE: begin
            cmd <= rx_data;
            cnt <= '0;
          end
          REGSEL: sel <= rx_data[IW-1:0];
          HEXDATA: begin
            acc <= {acc[WIDTH-5:0], hex_val(rx_data)};
            cnt <= cnt + 5'd1;
          end
          OPNAME: begin
            name <= {name[7:0], rx_data};
            code <= mnem({name, rx_data});
            cnt  <= (cnt == 5'd2) ? 5'd0 : cnt + 5'd1;
          end
          OPREGS: begin
            case (cnt)
              5'd0:    s0  <= rx_data[IW-1:0];
              5'd1:    s1  <= rx_data[IW-1:0];
              default: dst <= rx_data[3:0];
            endcase
            cnt <= cnt + 5'd1;
          end
          default: ;
        endcase
      end

      // Host write has priority over a write-back aimed at the same register.
      for (int i = 0; i < NREGS; i++) begin
        if (wr_host && sel == IW'(i))              regs[i] <= acc;
        else if (res_valid && res_dst == 4'(i))    regs[i] <= res_data;
      end

      if (issue) begin
        op_valid <= 1'b1;
        op_code  <= code;
        op_src0  <= regs[s0];
        op_src1  <= regs[s1];
        op_dst   <= dst;
      end else if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end

      // tx_data holds the byte on the wire; rbuf holds the rcnt bytes still to go.
      if (rep_k || rep_e) begin
        tx_valid <= 1'b1;
        tx_data  <= rep_k ? 8'h6B : 8'h65;
        rbuf     <= {LF, {(N*8-8){1'b0}}};
        rcnt     <= 5'd1;
      end else if (rep_hex) begin
        tx_valid <= 1'b1;
        tx_data  <= rd_str[N*8-1 -: 8];
        rbuf     <= {rd_str[N*8-9:0], LF};
        rcnt     <= N5;
      end else if (tx_fire) begin
        if (rcnt == 5'd0) begin
          tx_valid <= 1'b0;
        end else begin
          tx_data <= rbuf[N*8-1 -: 8];
          rbuf    <= rbuf << 8;
          rcnt    <= rcnt - 5'd1;
        end
      end

      if (rep_e && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cmd_regserver.sv
// Bench for cmd_regserver: command table plus hand-built op, write-back,
// backpressure and reset sequences; reply bytes checked against a queue.
module tb_cmd_regserver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [3:0]  op_code;
  logic [31:0] op_src0, op_src1;
  logic [3:0]  op_dst;
  logic        res_valid = 1'b0;
  logic [3:0]  res_dst = '0;
  logic [31:0] res_data = '0;
  logic [15:0] err_count;

  logic        rx16_valid = 1'b0;
  logic [7:0]  rx16_data = '0;
  logic        rx16_ready;
  logic        tx16_valid;
  logic [7:0]  tx16_data;
  logic        tx16_ready = 1'b1;
  logic        op16_valid;
  logic        op16_ready = 1'b1;
  logic [3:0]  op16_code;
  logic [15:0] op16_src0, op16_src1;
  logic [3:0]  op16_dst;
  logic        res16_valid = 1'b0;
  logic [3:0]  res16_dst = '0;
  logic [15:0] res16_data = '0;
  logic [15:0] err16;

  cmd_regserver #(.WIDTH(32), .NREGS(8), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_src0(op_src0), .op_src1(op_src1), .op_dst(op_dst),
    .res_valid(res_valid), .res_dst(res_dst), .res_data(res_data),
    .err_count(err_count)
  );

  cmd_regserver #(.WIDTH(16), .NREGS(4), .OPW(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx16_valid), .rx_data(rx16_data), .rx_ready(rx16_ready),
    .tx_valid(tx16_valid), .tx_data(tx16_data), .tx_ready(tx16_ready),
    .op_valid(op16_valid), .op_ready(op16_ready), .op_code(op16_code),
    .op_src0(op16_src0), .op_src1(op16_src1), .op_dst(op16_dst),
    .res_valid(res16_valid), .res_dst(res16_dst), .res_data(res16_data),
    .err_count(err16)
  );

  typedef struct {
    string cmd;
    string rep;
    int    err;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got16[$];
  vec_t       vt[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic mon();
    logic       held;
    logic [7:0] held_d;
    logic [7:0] e;
    held = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("tx_hold_valid", tx_valid, 1);
          chk("tx_hold_data", tx_data, held_d);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_extra: got %0h want no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_data, e);
          end
          held = 1'b0;
        end else if (tx_valid) begin
          held = 1'b1;
          held_d = tx_data;
        end else begin
          held = 1'b0;
        end
      end
    end
  endtask

  task automatic mon16();
    forever begin
      @(negedge clk);
      if (rst_n && tx16_valid && tx16_ready) got16.push_back(tx16_data);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rx_accept", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b);
    int t;
    t = 0;
    rx16_valid = 1'b1;
    rx16_data  = b;
    @(negedge clk);
    while (!rx16_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rx16_accept", rx16_ready, 1);
    @(posedge clk);
    #1;
    rx16_valid = 1'b0;
  endtask

  task automatic send_chars(input string s);
    for (int k = 0; k < s.len(); k++) send(s[k]);
  endtask

  task automatic send_line(input string s);
    send_chars(s);
    send(8'h0A);
  endtask

  task automatic push_exp(input string s);
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s16;
    int    t;
    vt[0]  = '{"w3deadbeef",  "k\n",         0};
    vt[1]  = '{"r3",          "deadbeef\n",  0};
    vt[2]  = '{"w4CAFEf00d",  "k\n",         0};
    vt[3]  = '{"r4",          "cafef00d\n",  0};
    vt[4]  = '{"",            "",            0};
    vt[5]  = '{"w9",          "e\n",         1};
    vt[6]  = '{"oxyz012",     "e\n",         2};
    vt[7]  = '{"w01234567",   "e\n",         3};
    vt[8]  = '{"r1x",         "e\n",         4};
    vt[9]  = '{"w0123456789", "e\n",         5};
    vt[10] = '{"q",           "e\n",         6};
    vt[11] = '{"r\r3",        "deadbeef\n",  6};
    vt[12] = '{"omul345",     "k\n",         6};
    vt[13] = '{"osub0a1",     "e\n",         7};
    vt[14] = '{"w000000001",  "k\n",         7};
    vt[15] = '{"w100000002",  "k\n",         7};
    vt[16] = '{"r0",          "00000001\n",  7};
    vt[17] = '{"\r",          "",            7};
    vt[18] = '{"w3",          "e\n",         8};
    vt[19] = '{"r1",          "00000002\n",  8};

    fork
      mon();
      mon16();
    join_none

    // reset state
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_op_src0", op_src0, 0);
    chk("rst_op_dst", op_dst, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      push_exp(vt[i].rep);
      send_line(vt[i].cmd);
      drain("vec_drain");
      chk("vec_err_count", err_count, vt[i].err);
    end

    // op issue held off by op_ready
    op_ready = 1'b0;
    push_exp("k\n");
    send_line("oadd012");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("op_valid_hold", op_valid, 1);
      chk("op_code", op_code, 1);
      chk("op_src0", op_src0, 1);
      chk("op_src1", op_src1, 2);
      chk("op_dst", op_dst, 2);
      chk("op_no_tx", tx_valid, 0);
      chk("op_rx_ready", rx_ready, 0);
    end
    @(posedge clk);
    #1;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    @(negedge clk);
    chk("op_valid_fall", op_valid, 0);
    chk("op_k_valid", tx_valid, 1);
    chk("op_k_data", tx_data, 8'h6B);
    drain("op_drain");
    op_ready = 1'b1;
    res_valid = 1'b1;
    res_dst = 4'd2;
    res_data = 32'd3;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    push_exp("00000003\n");
    send_line("r2");
    drain("wb_drain");

    // host write and write-back in the same cycle
    push_exp("k\n");
    send_chars("w511111111");
    rx_valid = 1'b1;
    rx_data = 8'h0A;
    res_valid = 1'b1;
    res_dst = 4'd5;
    res_data = 32'h99999999;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    res_valid = 1'b0;
    drain("same_drain");
    push_exp("11111111\n");
    send_line("r5");
    drain("same_rd");
    push_exp("k\n");
    send_chars("w622222222");
    rx_valid = 1'b1;
    rx_data = 8'h0A;
    res_valid = 1'b1;
    res_dst = 4'd7;
    res_data = 32'h77777777;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    res_valid = 1'b0;
    push_exp("22222222\n");
    send_line("r6");
    push_exp("77777777\n");
    send_line("r7");
    drain("diff_rd");

    // out-of-range write-back tags are dropped
    res_valid = 1'b1;
    res_dst = 4'd9;
    res_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    res_dst = 4'd13;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    push_exp("00000002\n");
    send_line("r1");
    push_exp("11111111\n");
    send_line("r5");
    drain("drop_rd");

    // write-back landing after the read snapshot
    tx_ready = 1'b0;
    push_exp("deadbeef\n");
    send_line("r3");
    res_valid = 1'b1;
    res_dst = 4'd3;
    res_data = 32'h12345678;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    tx_ready = 1'b1;
    drain("snap_drain");
    push_exp("12345678\n");
    send_line("r3");
    drain("snap_rd");

    // reply under toggling tx_ready
    push_exp("12345678\n");
    send_line("r3");
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    drain("bp_drain");

    // asynchronous reset in the middle of a reply
    tx_ready = 1'b0;
    send_line("r3");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_op_valid", op_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_exp("00000000\n");
    send_line("r3");
    drain("post_rst_rd");

    // narrow build
    s16 = "w2a5c3\nr2\nw4\n";
    for (int k = 0; k < s16.len(); k++) send16(s16[k]);
    s16 = "k\na5c3\ne\n";
    t = 0;
    while (got16.size() < s16.len() && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("w16_len", got16.size(), s16.len());
    for (int k = 0; k < s16.len(); k++) begin
      if (k < got16.size()) chk("w16_byte", got16[k], s16[k]);
    end
    chk("w16_err", err16, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
